// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core port (C), debug/DMA port (D) and memory-side signals for dmem_port_arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port DMEM between the core (C) and debug/DMA (D) ports,
// with a per-port burst limit. Grants are combinational; load data returns one cycle after grant.
// Optional stall counters are enabled with the ARB_PERF_CNT_EN macro.
module dmem_port_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0] perf_c_stall,
  output logic [15:0] perf_d_stall,
`endif
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  // last_gnt: 0 = C, 1 = D
  logic          last_gnt;
  logic [BW-1:0] burst_cnt;
  logic          rd_pend_c;
  logic          rd_pend_d;

  logic          in_burst;
  logic          pick_d;
  logic          c_gnt;
  logic          d_gnt;
  logic          we_mux;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // Arbitration: a port in an unfinished burst keeps the grant on a tie, otherwise alternate
  always_comb begin
    in_burst = 1'b0;
    pick_d   = 1'b0;
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    // burst_cnt != 0 means last_gnt was granted in the previous cycle
    in_burst = (burst_cnt != '0) && (burst_cnt < BURST_MAX) &&
               (last_gnt ? bus.d_req : bus.c_req);
    if (bus.c_req && bus.d_req) begin
      pick_d = in_burst ? last_gnt : ~last_gnt;
    end else begin
      pick_d = bus.d_req;
    end
    // Nothing is issued while reset is asserted
    c_gnt = rst_n & bus.c_req & ~pick_d;
    d_gnt = rst_n & bus.d_req & pick_d;
  end

  // Memory-side mux from the granted port; all zero when idle
  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (c_gnt) begin
      we_mux    = bus.c_we;
      addr_mux  = bus.c_addr;
      wdata_mux = bus.c_wdata;
    end else if (d_gnt) begin
      we_mux    = bus.d_we;
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
    end
  end

  assign bus.c_gnt     = c_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = c_gnt | d_gnt;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  // Read return: pending flags are masked during reset so stale data never escapes
  assign bus.c_rvalid = rst_n & rd_pend_c;
  assign bus.d_rvalid = rst_n & rd_pend_d;
  assign bus.c_rdata  = (rst_n & rd_pend_c) ? bus.mem_rdata : '0;
  assign bus.d_rdata  = (rst_n & rd_pend_d) ? bus.mem_rdata : '0;

  // Arbitration history and read-pending tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      rd_pend_c <= 1'b0;
      rd_pend_d <= 1'b0;
    end else begin
      rd_pend_c <= c_gnt & ~bus.c_we;
      rd_pend_d <= d_gnt & ~bus.d_we;
      if (c_gnt || d_gnt) begin
        last_gnt <= d_gnt;
        if ((burst_cnt != '0) && (d_gnt == last_gnt)) begin
          burst_cnt <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + BW'(1);
        end else begin
          burst_cnt <= BW'(1);
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating count of cycles each port spends requesting without a grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_c_stall <= '0;
      perf_d_stall <= '0;
    end else begin
      if (bus.c_req && !c_gnt && (perf_c_stall != 16'hFFFF)) begin
        perf_c_stall <= perf_c_stall + 16'd1;
      end
      if (bus.d_req && !d_gnt && (perf_d_stall != 16'hFFFF)) begin
        perf_d_stall <= perf_d_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_c_stall;
  logic [15:0] perf_d_stall;
`endif

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ARB_PERF_CNT_EN
    .perf_c_stall (perf_c_stall),
    .perf_d_stall (perf_d_stall),
`endif
    .bus          (bus)
  );

  // Memory model: synchronous write, read data valid the cycle after the access
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        e_cg, e_dg, e_cv;
    logic [31:0] e_cd;
    logic        e_dv;
    logic [31:0] e_dd;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic ecg, input logic edg, input logic ecv, input logic [31:0] ecd,
    input logic edv, input logic [31:0] edd,
    input logic een, input logic ewe, input logic [31:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_cg = ecg; v.e_dg = edg; v.e_cv = ecv; v.e_cd = ecd;
    v.e_dv = edv; v.e_dd = edd;
    v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Apply a reset cycle with no requests
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
  endtask

  logic exp_d_seq [10];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    mem[4] = 32'hDEADBEEF;

    // Rows are consecutive cycles starting the first cycle after reset
    vq.push_back(mk(1,0,32'h10,0, 0,0,0,0,      1,0, 0,0,            0,0,            1,0,32'h10,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 1,32'hDEADBEEF, 0,0,            0,0,0,0));
    vq.push_back(mk(0,0,0,0,      1,1,32'h20,32'h55, 0,1, 0,0,       0,0,            1,1,32'h20,32'h55));
    vq.push_back(mk(1,0,32'h20,0, 0,0,0,0,      1,0, 0,0,            0,0,            1,0,32'h20,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 1,32'h55,       0,0,            0,0,0,0));
    vq.push_back(mk(1,0,32'h0,0,  0,0,0,0,      1,0, 0,0,            0,0,            1,0,32'h0,0));
    vq.push_back(mk(1,0,32'h4,0,  0,0,0,0,      1,0, 1,32'h11111111, 0,0,            1,0,32'h4,0));
    vq.push_back(mk(1,0,32'h8,0,  0,0,0,0,      1,0, 1,32'h22222222, 0,0,            1,0,32'h8,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 1,32'h33333333, 0,0,            0,0,0,0));
    vq.push_back(mk(0,0,0,0,      1,0,32'h10,0, 0,1, 0,0,            0,0,            1,0,32'h10,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 0,0,            1,32'hDEADBEEF, 0,0,0,0));
    vq.push_back(mk(1,0,32'h0,0,  1,0,32'h4,0,  1,0, 0,0,            0,0,            1,0,32'h0,0));
    vq.push_back(mk(0,0,0,0,      1,0,32'h4,0,  0,1, 1,32'h11111111, 0,0,            1,0,32'h4,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 0,0,            1,32'h22222222, 0,0,0,0));
    vq.push_back(mk(1,1,32'h8,32'hCAFE, 1,0,32'hC,0, 1,0, 0,0,      0,0,            1,1,32'h8,32'hCAFE));
    vq.push_back(mk(0,0,0,0,      1,0,32'hC,0,  0,1, 0,0,            0,0,            1,0,32'hC,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 0,0,            1,32'h44444444, 0,0,0,0));
    vq.push_back(mk(1,0,32'h8,0,  0,0,0,0,      1,0, 0,0,            0,0,            1,0,32'h8,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,0, 1,32'hCAFE,     0,0,            0,0,0,0));

    // Reset cycle with both ports requesting: everything must stay quiet
    rst_n = 1'b0;
    drive(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h99);
    @(negedge clk);
    #1;
    chk("rst c_gnt",  32'(bus.c_gnt),  0);
    chk("rst d_gnt",  32'(bus.d_gnt),  0);
    chk("rst mem_en", 32'(bus.mem_en), 0);
    chk("rst mem_addr", bus.mem_addr, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vq[i].c_req, vq[i].c_we, vq[i].c_addr, vq[i].c_wdata,
            vq[i].d_req, vq[i].d_we, vq[i].d_addr, vq[i].d_wdata);
      #1;
      chk($sformatf("r%0d c_gnt", i),     32'(bus.c_gnt),    32'(vq[i].e_cg));
      chk($sformatf("r%0d d_gnt", i),     32'(bus.d_gnt),    32'(vq[i].e_dg));
      chk($sformatf("r%0d c_rvalid", i),  32'(bus.c_rvalid), 32'(vq[i].e_cv));
      chk($sformatf("r%0d c_rdata", i),   bus.c_rdata,       vq[i].e_cd);
      chk($sformatf("r%0d d_rvalid", i),  32'(bus.d_rvalid), 32'(vq[i].e_dv));
      chk($sformatf("r%0d d_rdata", i),   bus.d_rdata,       vq[i].e_dd);
      chk($sformatf("r%0d mem_en", i),    32'(bus.mem_en),   32'(vq[i].e_en));
      chk($sformatf("r%0d mem_we", i),    32'(bus.mem_we),   32'(vq[i].e_we));
      chk($sformatf("r%0d mem_addr", i),  bus.mem_addr,      vq[i].e_addr);
      chk($sformatf("r%0d mem_wdata", i), bus.mem_wdata,     vq[i].e_wdata);
    end

    // Both ports held for 10 cycles from reset: bursts of 4 alternate C then D
    exp_d_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      #1;
      chk($sformatf("burst%0d c_gnt", i), 32'(bus.c_gnt), 32'(!exp_d_seq[i]));
      chk($sformatf("burst%0d d_gnt", i), 32'(bus.d_gnt), 32'(exp_d_seq[i]));
    end

    // Reset right after a D load grant discards the pending read
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
    #1;
    chk("r5 c load gnt", 32'(bus.c_gnt), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
    #1;
    chk("r5 d load gnt", 32'(bus.d_gnt), 1);
    chk("r5 c_rvalid", 32'(bus.c_rvalid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    #1;
    chk("r5 rst d_rvalid", 32'(bus.d_rvalid), 0);
    chk("r5 rst d_rdata",  bus.d_rdata,       0);
    chk("r5 rst c_gnt",    32'(bus.c_gnt),    0);
    chk("r5 rst d_gnt",    32'(bus.d_gnt),    0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    chk("r5 post d_rvalid", 32'(bus.d_rvalid), 0);
    chk("r5 post c_rvalid", 32'(bus.c_rvalid), 0);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    #1;
    chk("r5 tie c_gnt", 32'(bus.c_gnt), 1);
    chk("r5 tie d_gnt", 32'(bus.d_gnt), 0);

    // After a C grant, reset must still hand the next tie to C
    @(negedge clk);
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
    #1;
    chk("rc c gnt", 32'(bus.c_gnt), 1);
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    #1;
    chk("rc tie c_gnt", 32'(bus.c_gnt), 1);
    chk("rc tie d_gnt", 32'(bus.d_gnt), 0);

`ifdef ARB_PERF_CNT_EN
    // D waits behind a 4-cycle C burst, then is served for 2 cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(i < 4, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("perf_d_stall", 32'(perf_d_stall), 4);
    chk("perf_c_stall", 32'(perf_c_stall), 0);
`endif

    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
